bip_dump_unit: RTL and testbench

//   Read-out end of the BIP. On CPU halt, snapshots the cycle counter and streams it,

---
 rtl/bip_pkg.sv | 36 +++
 rtl/bip_dump_unit_if.sv | 30 +++
 rtl/bip_byte_sender.sv | 45 ++++
 rtl/bip_dump_unit.sv | 108 ++++++++++
 tb/tb_bip_dump_unit.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/bip_pkg.sv
// Shared constants for the BIP read-out path: frame format, FSM and byte-sender state codes.
// No logic; pure definitions.
// Imported by the dump unit, its byte sender, the bus interface and the bench.
package bip_pkg;

    localparam int NB_ADDR    = 11;
    localparam int RAM_WIDTH  = 16;
    localparam int NB_DM_ADDR = 10;
    localparam int N_WORDS    = 16;

    localparam logic [7:0] HEADER = 8'hA5;

    // Dump FSM state codes
    localparam logic [3:0] ST_IDLE = 4'd0;
    localparam logic [3:0] ST_HDR  = 4'd1;
    localparam logic [3:0] ST_CHI  = 4'd2;
    localparam logic [3:0] ST_CLO  = 4'd3;
    localparam logic [3:0] ST_RD   = 4'd4;
    localparam logic [3:0] ST_RDW  = 4'd5;
    localparam logic [3:0] ST_DHI  = 4'd6;
    localparam logic [3:0] ST_DLO  = 4'd7;
    localparam logic [3:0] ST_FIN  = 4'd8;

    // Byte sender state codes
    localparam logic [1:0] SND_IDLE  = 2'd0;
    localparam logic [1:0] SND_GUARD = 2'd1;
    localparam logic [1:0] SND_WAIT  = 2'd2;

    // Header + 16-bit counter + two bytes per dumped word
    function automatic int frame_bytes(input int n_words);
        return 3 + 2 * n_words;
    endfunction

    localparam int FRAME_BYTES = frame_bytes(N_WORDS);

endpackage

// File: rtl/bip_dump_unit_if.sv
// Bus bundle between the dump unit and its neighbours (CPU halt, counter, DM port, UART TX).
// No latency; wires only.
// master = dump unit side, slave = the surrounding BIP top / bench side.
interface bip_dump_unit_if
    import bip_pkg::*;
#(
    parameter int NB_ADDR_P    = NB_ADDR,
    parameter int RAM_WIDTH_P  = RAM_WIDTH,
    parameter int NB_DM_ADDR_P = NB_DM_ADDR
);
    logic                    i_halt;
    logic [NB_ADDR_P-1:0]    i_counter;
    logic [NB_DM_ADDR_P-1:0] o_dm_addr;
    logic [RAM_WIDTH_P-1:0]  i_dm_data;
    logic [7:0]              o_tx_data;
    logic                    o_tx_start;
    logic                    i_tx_busy;
    logic                    o_busy;
    logic                    o_done;

    modport master (
        input  i_halt, i_counter, i_dm_data, i_tx_busy,
        output o_dm_addr, o_tx_data, o_tx_start, o_busy, o_done
    );

    modport slave (
        output i_halt, i_counter, i_dm_data, i_tx_busy,
        input  o_dm_addr, o_tx_data, o_tx_start, o_busy, o_done
    );
endinterface

// File: rtl/bip_byte_sender.sv
// Hands one byte to a UART transmitter: start pulse, one guard cycle, then wait for busy low.
// Start issues 1 cycle after req seen with tx idle; sent pulses when the byte's busy falls.
// Holds off while tx_busy is high; req is ignored until the current byte completes.
module bip_byte_sender
    import bip_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic [7:0] data,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic       sent
);
    logic [1:0] state;

    // The guard cycle covers the gap before the transmitter raises busy
    assign sent = (state == SND_WAIT) && !tx_busy;

    // Start/guard/wait sequencing; tx_data is only reloaded on a new start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SND_IDLE;
            tx_data  <= 8'h00;
            tx_start <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                SND_IDLE: begin
                    if (req && !tx_busy) begin
                        tx_start <= 1'b1;
                        tx_data  <= data;
                        state    <= SND_GUARD;
                    end
                end
                SND_GUARD: state <= SND_WAIT;
                SND_WAIT: begin
                    if (!tx_busy) state <= SND_IDLE;
                end
                default: state <= SND_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/bip_dump_unit.sv
// On CPU halt rising edge, sends A5, 16-bit cycle snapshot, then DM words 0..N_WORDS-1 (MSB first).
// Frame starts 2 cycles after the halt edge; DM read takes RD+RDW (1-cycle RAM latency).
// Each byte waits for the transmitter to go idle; a stuck busy stalls the frame indefinitely.
module bip_dump_unit
    import bip_pkg::*;
#(
    parameter int N_WORDS_P = N_WORDS
)(
    input  logic             i_clk,
    input  logic             i_rst,
    bip_dump_unit_if.master  bus
);
    logic [3:0]            state;
    logic                  halt_q;
    logic                  halt_rise;
    logic [NB_ADDR-1:0]    snap;
    logic [15:0]           cnt_ext;
    logic [NB_DM_ADDR-1:0] idx;
    logic [NB_DM_ADDR-1:0] dm_addr;
    logic [15:0]           word;
    logic                  req;
    logic [7:0]            tx_byte;
    logic                  sent;

    localparam logic [NB_DM_ADDR-1:0] LAST_IDX = NB_DM_ADDR'(N_WORDS_P - 1);

    assign halt_rise      = bus.i_halt && !halt_q;
    assign cnt_ext        = 16'(snap);
    assign bus.o_dm_addr  = dm_addr;
    assign bus.o_busy     = (state != ST_IDLE);
    assign bus.o_done     = (state == ST_FIN);

    // Select the byte offered to the sender in each transmitting state
    always_comb begin
        req     = 1'b0;
        tx_byte = 8'h00;
        case (state)
            ST_HDR: begin req = 1'b1; tx_byte = HEADER;         end
            ST_CHI: begin req = 1'b1; tx_byte = cnt_ext[15:8];  end
            ST_CLO: begin req = 1'b1; tx_byte = cnt_ext[7:0];   end
            ST_DHI: begin req = 1'b1; tx_byte = word[15:8];     end
            ST_DLO: begin req = 1'b1; tx_byte = word[7:0];      end
            default: ;
        endcase
    end

    // Frame sequencing, counter snapshot and DM walk. halt_q resets high so a
    // halt already asserted across reset needs a fresh rising edge to start a frame.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state   <= ST_IDLE;
            halt_q  <= 1'b1;
            snap    <= '0;
            idx     <= '0;
            dm_addr <= '0;
            word    <= '0;
        end else begin
            halt_q <= bus.i_halt;
            case (state)
                ST_IDLE: begin
                    if (halt_rise) begin
                        snap  <= bus.i_counter;
                        idx   <= '0;
                        state <= ST_HDR;
                    end
                end
                ST_HDR: if (sent) state <= ST_CHI;
                ST_CHI: if (sent) state <= ST_CLO;
                ST_CLO: begin
                    if (sent) begin
                        dm_addr <= '0;
                        state   <= ST_RD;
                    end
                end
                ST_RD:  state <= ST_RDW;
                ST_RDW: begin
                    word  <= 16'(bus.i_dm_data);
                    state <= ST_DHI;
                end
                ST_DHI: if (sent) state <= ST_DLO;
                ST_DLO: begin
                    if (sent) begin
                        if (idx == LAST_IDX) begin
                            state <= ST_FIN;
                        end else begin
                            idx     <= idx + 1'b1;
                            dm_addr <= idx + 1'b1;
                            state   <= ST_RD;
                        end
                    end
                end
                ST_FIN:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    bip_byte_sender u_sender (
        .clk      (i_clk),
        .rst_n    (i_rst),
        .req      (req),
        .data     (tx_byte),
        .tx_busy  (bus.i_tx_busy),
        .tx_data  (bus.o_tx_data),
        .tx_start (bus.o_tx_start),
        .sent     (sent)
    );
endmodule

// File: tb/tb_bip_dump_unit.sv
// Bench for bip_dump_unit: randomized frames against a frame-level model, checked by a byte monitor.
module tb_bip_dump_unit;
    import bip_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bip_dump_unit_if bus ();

    bip_dump_unit dut (
        .i_clk (clk),
        .i_rst (rst_n),
        .bus   (bus)
    );

    logic [15:0] mem [0:1023];
    int          busy_len = 2;
    int          busy_cnt = 0;
    logic [7:0]  exp_q [$];
    int          checks = 0;
    int          errors = 0;
    int          start_cnt = 0;

    // Synchronous-read data memory
    always @(posedge clk) bus.i_dm_data <= mem[bus.o_dm_addr];

    // UART transmitter model: busy for busy_len cycles starting the cycle after a start
    always @(posedge clk) begin
        if (bus.o_tx_start) busy_cnt <= busy_len;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign bus.i_tx_busy = (busy_cnt > 0);

    // Monitor: every start must happen with the TX idle and carry the next expected byte
    always @(negedge clk) begin
        if (bus.o_tx_start) begin
            start_cnt++;
            checks++;
            if (bus.i_tx_busy) begin
                errors++;
                $display("FAIL start_while_busy actual busy=1 required busy=0");
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL tx_byte unexpected start data=%02h required no start", bus.o_tx_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (bus.o_tx_data !== e) begin
                    errors++;
                    $display("FAIL tx_byte actual=%02h required=%02h", bus.o_tx_data, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference frame: header, counter as 16-bit big-endian, then each word big-endian
    task automatic push_frame(input logic [10:0] cnt);
        int c;
        c = int'(cnt);
        exp_q.push_back(HEADER);
        exp_q.push_back(8'(c / 256));
        exp_q.push_back(8'(c % 256));
        for (int i = 0; i < N_WORDS; i++) begin
            exp_q.push_back(8'(int'(mem[i]) / 256));
            exp_q.push_back(8'(int'(mem[i]) % 256));
        end
    endtask

    // One halt edge -> one full frame; halt is left high afterwards
    task automatic run_frame(input logic [10:0] cnt, input int blen, input bit glitch);
        int s0;
        int dones;
        busy_len = blen;
        push_frame(cnt);
        @(negedge clk);
        bus.i_counter = cnt;
        bus.i_halt    = 1'b0;
        repeat (2) @(negedge clk);
        bus.i_halt = 1'b1;
        s0 = start_cnt;
        @(negedge clk);
        bus.i_counter = 11'h7FF;
        check("busy_after_halt", 32'(bus.o_busy), 32'd1);
        dones = 0;
        for (int k = 0; k < 8000 && dones == 0; k++) begin
            @(negedge clk);
            if (glitch && k == 60) bus.i_halt = 1'b0;
            if (glitch && k == 62) bus.i_halt = 1'b1;
            if (bus.o_done) dones++;
        end
        check("done_seen", 32'(dones), 32'd1);
        check("frame_starts", 32'(start_cnt - s0), 32'(FRAME_BYTES));
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check("done_single", 32'(bus.o_done), 32'd0);
        check("idle_after", 32'(bus.o_busy), 32'd0);
        repeat (40) @(negedge clk);
        check("no_retrigger", 32'(start_cnt - s0), 32'(FRAME_BYTES));
        exp_q.delete();
    endtask

    initial begin
        logic [10:0] c;
        int s0;
        int s1;
        bit hit;

        bus.i_halt    = 1'b1;
        bus.i_counter = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;

        // Reset with halt held high
        repeat (3) @(negedge clk);
        check("rst_tx_start", 32'(bus.o_tx_start), 32'd0);
        check("rst_tx_data", 32'(bus.o_tx_data), 32'd0);
        check("rst_dm_addr", 32'(bus.o_dm_addr), 32'd0);
        check("rst_busy", 32'(bus.o_busy), 32'd0);
        check("rst_done", 32'(bus.o_done), 32'd0);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("no_start_after_rst", 32'(start_cnt), 32'd0);
        check("idle_after_rst", 32'(bus.o_busy), 32'd0);

        // Basic frame, counter changes after the edge
        for (int i = 0; i < N_WORDS; i++) mem[i] = 16'h1000 + 16'(i);
        run_frame(11'h5C3, 2, 1'b0);

        // Slow transmitter, then a second halt pulse gives an identical frame
        run_frame(11'h5C3, 10, 1'b0);
        run_frame(11'h5C3, 10, 1'b1);

        // Randomized frames
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < N_WORDS; i++) mem[i] = 16'($urandom);
            c = 11'($urandom);
            run_frame(c, int'($urandom_range(1, 12)), 1'($urandom));
        end

        // Reset after the 7th byte aborts the frame
        busy_len = 4;
        c = 11'($urandom);
        push_frame(c);
        @(negedge clk);
        bus.i_counter = c;
        bus.i_halt    = 1'b0;
        repeat (2) @(negedge clk);
        bus.i_halt = 1'b1;
        s0  = start_cnt;
        hit = 1'b0;
        for (int k = 0; k < 4000 && !hit; k++) begin
            @(negedge clk);
            if (start_cnt - s0 >= 7) hit = 1'b1;
        end
        check("reached_7th_byte", 32'(hit), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(bus.o_busy), 32'd0);
        check("abort_tx_start", 32'(bus.o_tx_start), 32'd0);
        exp_q.delete();
        s1 = start_cnt;
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("no_resume", 32'(start_cnt - s1), 32'd0);
        check("idle_after_abort", 32'(bus.o_busy), 32'd0);
        for (int i = 0; i < N_WORDS; i++) mem[i] = 16'($urandom);
        run_frame(11'($urandom), 3, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
